// File: rtl/exe_pipe_stage_pkg.sv
// Shared definitions for the execute pipeline stage.
//   - ex_cmd operation encodings
//   - bit positions inside the 5-bit control bundle {S, B, WB_en, mem_write, mem_read}
//   - bit positions inside the status register {N, Z, C, V}
//   - FSM state enum (MUL_BUSY only exists when EXE_PIPE_STAGE_MUL_EN is defined)
package exe_pipe_stage_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001,
        CMD_MUL = 4'b1100
    } ex_cmd_e;

    localparam int unsigned CTRL_MEM_READ  = 0;
    localparam int unsigned CTRL_MEM_WRITE = 1;
    localparam int unsigned CTRL_WB_EN     = 2;
    localparam int unsigned CTRL_B         = 3;
    localparam int unsigned CTRL_S         = 4;

    localparam int unsigned SR_N = 3;
    localparam int unsigned SR_Z = 2;
    localparam int unsigned SR_C = 1;
    localparam int unsigned SR_V = 0;

`ifdef EXE_PIPE_STAGE_MUL_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FULL     = 2'd1,
        MUL_BUSY = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;
`endif

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   cmd    : effective operation (ex_cmd encoding)
//   op_a   : operand 1 (val_rn)
//   op_b   : operand 2 (val2)
//   c_in   : registered carry flag, used by ADC/SBC
//   res    : result (0 for undefined commands, including MUL)
//   flags  : {N, Z, C, V} computed from res
//   upd_nz : operation is allowed to update N and Z
//   upd_cv : operation is allowed to update C and V
module exe_alu
    import exe_pipe_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags,
    output logic             upd_nz,
    output logic             upd_cv
);

    logic [WIDTH:0] sum;
    logic           v;

    always_comb begin
        sum    = '0;
        res    = '0;
        v      = 1'b0;
        upd_nz = 1'b0;
        upd_cv = 1'b0;
        case (cmd)
            CMD_MOV: begin res = op_b;         upd_nz = 1'b1; end
            CMD_MVN: begin res = ~op_b;        upd_nz = 1'b1; end
            CMD_AND: begin res = op_a & op_b;  upd_nz = 1'b1; end
            CMD_ORR: begin res = op_a | op_b;  upd_nz = 1'b1; end
            CMD_EOR: begin res = op_a ^ op_b;  upd_nz = 1'b1; end
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, op_a} + {1'b0, op_b}
                    + ((cmd == CMD_ADC) ? (WIDTH+1)'(c_in) : '0);
                res = sum[WIDTH-1:0];
                v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
                upd_nz = 1'b1;
                upd_cv = 1'b1;
            end
            CMD_SUB, CMD_SBC: begin
                // a - b - !C == a + ~b + C; plain SUB uses C = 1.
                // The carry-out is therefore NOT-borrow.
                sum = {1'b0, op_a} + {1'b0, ~op_b}
                    + ((cmd == CMD_SBC) ? (WIDTH+1)'(c_in) : (WIDTH+1)'(1'b1));
                res = sum[WIDTH-1:0];
                v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
                upd_nz = 1'b1;
                upd_cv = 1'b1;
            end
            default: ;
        endcase
    end

    assign flags = {res[WIDTH-1], (res == '0), sum[WIDTH], v};

endmodule

// File: rtl/exe_pipe_stage.sv
// Execute pipeline stage: one-entry output register with valid/ready handshake
// on both sides, NZCV status register, branch target adder and (optionally) an
// iterative shift-add multiplier.
// Configuration macro: EXE_PIPE_STAGE_MUL_EN enables MUL (WIDTH-cycle shift-add);
// without it ex_cmd 1100 behaves as an undefined op.
// Ports:
//   clk, rst (async, active-low), flush (sync kill)
//   in_valid/in_ready, ex_cmd, ctrl_in, val_rn, val2, val_rm, pc, simm, dst_in : upstream
//   out_valid/out_ready, ctrl_out, dst_out, val_rm_out, alu_res, branch_addr  : downstream
//   sr : status register {N,Z,C,V}
module exe_pipe_stage
    import exe_pipe_stage_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_DEPTH = 4,
    parameter int unsigned IMM_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           ex_cmd,
    input  logic [4:0]           ctrl_in,
    input  logic [WIDTH-1:0]     val_rn,
    input  logic [WIDTH-1:0]     val2,
    input  logic [WIDTH-1:0]     val_rm,
    input  logic [WIDTH-1:0]     pc,
    input  logic [IMM_WIDTH-1:0] simm,
    input  logic [REG_DEPTH-1:0] dst_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           ctrl_out,
    output logic [REG_DEPTH-1:0] dst_out,
    output logic [WIDTH-1:0]     val_rm_out,
    output logic [WIDTH-1:0]     alu_res,
    output logic [WIDTH-1:0]     branch_addr,
    output logic [3:0]           sr
);

    state_e           state_q, state_d;
    logic             is_mem;
    logic [3:0]       eff_cmd;
    logic             sr_wr_en;
    logic             accept;
    logic             go_mul;
    logic [WIDTH-1:0] alu_out;
    logic [3:0]       alu_flags;
    logic             alu_upd_nz, alu_upd_cv;
    logic [3:0]       sr_alu_nxt;
    logic [WIDTH-1:0] branch_nxt;

    // Loads and stores reuse the adder for address generation.
    assign is_mem   = ctrl_in[CTRL_MEM_READ] | ctrl_in[CTRL_MEM_WRITE];
    assign eff_cmd  = is_mem ? CMD_ADD : ex_cmd;
    assign sr_wr_en = ctrl_in[CTRL_S] & ~is_mem;

    exe_alu #(.WIDTH(WIDTH)) u_alu (
        .cmd    (eff_cmd),
        .op_a   (val_rn),
        .op_b   (val2),
        .c_in   (sr[SR_C]),
        .res    (alu_out),
        .flags  (alu_flags),
        .upd_nz (alu_upd_nz),
        .upd_cv (alu_upd_cv)
    );

    assign sr_alu_nxt = {alu_upd_nz ? alu_flags[3:2] : sr[3:2],
                         alu_upd_cv ? alu_flags[1:0] : sr[1:0]};

    assign branch_nxt = pc + {{(WIDTH-IMM_WIDTH){simm[IMM_WIDTH-1]}}, simm};

    assign in_ready  = (state_q == IDLE) | ((state_q == FULL) & out_ready);
    assign out_valid = (state_q == FULL);
    // flush wins over a simultaneous transfer.
    assign accept    = in_valid & in_ready & ~flush;

`ifdef EXE_PIPE_STAGE_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] mul_cnt;
    logic [WIDTH-1:0] mul_acc, mul_a, mul_b, mul_acc_nxt;
    logic             mul_s;
    logic             mul_last;

    assign go_mul      = (eff_cmd == CMD_MUL);
    assign mul_last    = (mul_cnt == CNT_W'(WIDTH-1));
    assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);
`else
    assign go_mul = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = go_mul ? state_e'(1 << 1) : FULL;
            end
            FULL: begin
                if (flush)          state_d = IDLE;
                else if (out_ready) state_d = accept ? (go_mul ? state_e'(1 << 1) : FULL) : IDLE;
            end
`ifdef EXE_PIPE_STAGE_MUL_EN
            MUL_BUSY: begin
                if (flush)         state_d = IDLE;
                else if (mul_last) state_d = FULL;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr          <= '0;
            alu_res     <= '0;
            branch_addr <= '0;
            ctrl_out    <= '0;
            dst_out     <= '0;
            val_rm_out  <= '0;
`ifdef EXE_PIPE_STAGE_MUL_EN
            mul_cnt     <= '0;
            mul_acc     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_s       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                alu_res     <= alu_out;
                branch_addr <= branch_nxt;
                ctrl_out    <= ctrl_in;
                dst_out     <= dst_in;
                val_rm_out  <= val_rm;
                if (sr_wr_en) sr <= sr_alu_nxt;
`ifdef EXE_PIPE_STAGE_MUL_EN
                mul_cnt <= '0;
                mul_acc <= '0;
                mul_a   <= val_rn;
                mul_b   <= val2;
                mul_s   <= sr_wr_en;
`endif
            end
`ifdef EXE_PIPE_STAGE_MUL_EN
            else if (state_q == MUL_BUSY) begin
                if (flush) begin
                    mul_cnt <= '0;
                end else begin
                    mul_acc <= mul_acc_nxt;
                    mul_a   <= mul_a << 1;
                    mul_b   <= mul_b >> 1;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_last) begin
                        alu_res <= mul_acc_nxt;
                        mul_cnt <= '0;
                        if (mul_s) sr[3:2] <= {mul_acc_nxt[WIDTH-1], (mul_acc_nxt == '0)};
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_exe_pipe_stage.sv
module tb_exe_pipe_stage;
    import exe_pipe_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  ex_cmd;
    logic [4:0]  ctrl_in, ctrl_out;
    logic [31:0] val_rn, val2, val_rm, pc, val_rm_out, alu_res, branch_addr;
    logic [23:0] simm;
    logic [3:0]  dst_in, dst_out, sr;

    exe_pipe_stage #(.WIDTH(32), .REG_DEPTH(4), .IMM_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_cmd(ex_cmd), .ctrl_in(ctrl_in),
        .val_rn(val_rn), .val2(val2), .val_rm(val_rm), .pc(pc),
        .simm(simm), .dst_in(dst_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .dst_out(dst_out), .val_rm_out(val_rm_out),
        .alu_res(alu_res), .branch_addr(branch_addr), .sr(sr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] br;
        logic [3:0]  sr;
        logic [4:0]  ctrl;
        logic [3:0]  dst;
        logic [31:0] rm;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   tag     = 0;

    localparam logic [4:0] S  = 5'b10000;
    localparam logic [4:0] NS = 5'b00000;
    localparam logic [4:0] LD = 5'b10001;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Monitor: every completed downstream transfer is checked against the queue head.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("alu_res",     alu_res,            e.res);
                chk("sr",          {28'b0, sr},        {28'b0, e.sr});
                chk("branch_addr", branch_addr,        e.br);
                chk("ctrl_out",    {27'b0, ctrl_out},  {27'b0, e.ctrl});
                chk("dst_out",     {28'b0, dst_out},   {28'b0, e.dst});
                chk("val_rm_out",  val_rm_out,         e.rm);
            end
        end
    end

    task automatic drive(input logic [3:0] cmd, input logic [4:0] ctrl,
                         input logic [31:0] rn, input logic [31:0] v2,
                         input logic [31:0] pcv, input logic [23:0] imm);
        tag++;
        ex_cmd  = cmd;
        ctrl_in = ctrl;
        val_rn  = rn;
        val2    = v2;
        pc      = pcv;
        simm    = imm;
        dst_in  = 4'(tag);
        val_rm  = 32'hA000_0000 + 32'(tag);
        in_valid = 1'b1;
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [3:0] s, input logic [31:0] b);
        exp_t e;
        e.res = r; e.sr = s; e.br = b;
        e.ctrl = ctrl_in; e.dst = dst_in; e.rm = val_rm;
        return e;
    endfunction

    // Issue one op, wait (bounded) for in_ready, optionally queue its expected result.
    task automatic send(input logic [3:0] cmd, input logic [4:0] ctrl,
                        input logic [31:0] rn, input logic [31:0] v2,
                        input logic [31:0] pcv, input logic [23:0] imm,
                        input logic [31:0] e_res, input logic [3:0] e_sr,
                        input logic [31:0] e_br, input bit push);
        int n = 0;
        drive(cmd, ctrl, rn, v2, pcv, imm);
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        if (push) exp_q.push_back(mk(e_res, e_sr, e_br));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ex_cmd = '0; ctrl_in = '0; val_rn = '0; val2 = '0; val_rm = '0;
        pc = '0; simm = '0; dst_in = '0;
        #3;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sr",        {28'b0, sr},        32'd0);
        chk("rst_alu_res",   alu_res,            32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // Back-to-back directed vectors; sr column is {N,Z,C,V}.
        send(CMD_ADD, S,  32'h7FFF_FFFF, 32'h1, 32'h100, 24'hFFFFFC, 32'h8000_0000, 4'b1001, 32'h0000_00FC, 1);
        chk("latency1_out_valid", {31'b0, out_valid}, 32'd1);
        send(CMD_SUB, S,  32'd5, 32'd5,  32'h1000, 24'h4, 32'd0, 4'b0110, 32'h1004, 1);
        send(CMD_ADC, S,  32'd1, 32'd1,  32'h0,    24'h4, 32'd3, 4'b0000, 32'h4,    1);
        send(CMD_SBC, S,  32'd10, 32'd3, 32'h10, 24'h80_0000, 32'd6, 4'b0010, 32'hFF80_0010, 1);
        send(CMD_AND, S,  32'hF0F0, 32'hFF00, 32'h0, 24'h0, 32'hF000, 4'b0010, 32'h0, 1);
        send(CMD_ORR, S,  32'h0, 32'h0, 32'h20, 24'h0, 32'h0, 4'b0110, 32'h20, 1);
        send(CMD_EOR, S,  32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0, 24'h8, 32'hFFFF_0000, 4'b1010, 32'h8, 1);
        send(CMD_MVN, NS, 32'h0, 32'h0, 32'h0, 24'h0, 32'hFFFF_FFFF, 4'b1010, 32'h0, 1);
        send(CMD_MOV, S,  32'h0, 32'h55, 32'h0, 24'h0, 32'h55, 4'b0010, 32'h0, 1);
        send(CMD_MOV, LD, 32'h1000, 32'h20, 32'h0, 24'h0, 32'h1020, 4'b0010, 32'h0, 1);
        send(CMD_NOP, S,  32'h7, 32'h9, 32'h0, 24'h0, 32'h0, 4'b0010, 32'h0, 1);
        send(CMD_SUB, S,  32'h0, 32'h1, 32'h0, 24'h0, 32'hFFFF_FFFF, 4'b1000, 32'h0, 1);
        send(CMD_SUB, S,  32'h8000_0000, 32'h1, 32'h0, 24'h0, 32'h7FFF_FFFF, 4'b0011, 32'h0, 1);
        drain();

        // Downstream stall for 3 cycles with a second op waiting.
        out_ready = 1'b0;
        send(CMD_ADD, NS, 32'd2, 32'd3, 32'h200, 24'h10, 32'd5, 4'b0011, 32'h210, 1);
        drive(CMD_ORR, NS, 32'd1, 32'd2, 32'h300, 24'h0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready",  {31'b0, in_ready},  32'd0);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_hold_res",  alu_res,            32'd5);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        exp_q.push_back(mk(32'd3, 4'b0011, 32'h300));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Flush coinciding with an offered op: nothing is accepted, sr untouched.
        drive(CMD_SUB, S, 32'd5, 32'd5, 32'h0, 24'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_accept_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_accept_sr",        {28'b0, sr},        32'h3);

`ifdef EXE_PIPE_STAGE_MUL_EN
        begin
            int n;
            drive(CMD_MUL, S, 32'h1234, 32'h10, 32'h0, 24'h0);
            chk("mul_in_ready_idle", {31'b0, in_ready}, 32'd1);
            exp_q.push_back(mk(32'h0001_2340, 4'b0011, 32'h0));
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clk); #1; n++;
            end
            chk("mul_busy_cycles", 32'(n), 32'd32);
            drain();

            // Flush mid-multiply.
            drive(CMD_MUL, S, 32'h0, 32'h5, 32'h0, 24'h0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (10) begin @(posedge clk); #1; end
            chk("mul_flush_busy", {31'b0, in_ready}, 32'd0);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            chk("mul_flush_out_valid", {31'b0, out_valid}, 32'd0);
            chk("mul_flush_sr",        {28'b0, sr},        32'h3);
            chk("mul_flush_in_ready",  {31'b0, in_ready},  32'd1);
            repeat (40) begin @(posedge clk); #1; end
            chk("mul_flush_no_output", {31'b0, out_valid}, 32'd0);

            // Asynchronous reset mid-multiply.
            drive(CMD_MUL, S, 32'd3, 32'd3, 32'h40, 24'h0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (5) begin @(posedge clk); #1; end
        end
`else
        // MUL encoding without the multiplier: undefined op, latency 1, sr untouched.
        send(CMD_MUL, S, 32'h1234, 32'h10, 32'h0, 24'h0, 32'h0, 4'b0011, 32'h0, 1);
        chk("mul_undef_latency", {31'b0, out_valid}, 32'd1);
        drain();

        // Flush of a held result.
        out_ready = 1'b0;
        send(CMD_ADD, NS, 32'd1, 32'd1, 32'h0, 24'h0, 32'd2, 4'b0011, 32'h0, 0);
        chk("held_out_valid", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("held_flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("held_flush_sr",        {28'b0, sr},        32'h3);
        out_ready = 1'b1;

        // Asynchronous reset with a result held downstream.
        out_ready = 1'b0;
        send(CMD_ADD, S, 32'd1, 32'd1, 32'h40, 24'h0, 32'd2, 4'b0000, 32'h40, 0);
`endif
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid",   {31'b0, out_valid},  32'd0);
        chk("arst_sr",          {28'b0, sr},         32'd0);
        chk("arst_alu_res",     alu_res,             32'd0);
        chk("arst_branch_addr", branch_addr,         32'd0);
        chk("arst_ctrl_out",    {27'b0, ctrl_out},   32'd0);
        chk("arst_dst_out",     {28'b0, dst_out},    32'd0);
        chk("arst_val_rm_out",  val_rm_out,          32'd0);
        chk("arst_in_ready",    {31'b0, in_ready},   32'd1);
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Operation after reset starts from a clean sr and state.
`ifdef EXE_PIPE_STAGE_MUL_EN
        send(CMD_MUL, S, 32'd2, 32'd3, 32'h0, 24'h0, 32'd6, 4'b0000, 32'h0, 1);
`else
        send(CMD_ADD, S, 32'd7, 32'd8, 32'h0, 24'h0, 32'd15, 4'b0000, 32'h0, 1);
`endif
        drain();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exe_pipe_stage.md
EXE_PIPE_STAGE -- requirements
Module: exe_pipe_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width (>=8).
REQ-002 The block SHALL have parameter REG_DEPTH, default 4, destination register index width.
REQ-003 The block SHALL have parameter IMM_WIDTH, default 24, signed branch offset width (<WIDTH).
REQ-004 Ports SHALL be: clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous kill of in-flight and held operations.
REQ-007 in_valid  input  1 / in_ready  output  1  upstream handshake.
REQ-008 ex_cmd  input  4  operation select.
REQ-009 ctrl_in  input  5  {S, B, WB_en, mem_write, mem_read}.
REQ-010 val_rn, val2, val_rm, pc  input  WIDTH each  operand 1, operand 2, store data, instruction PC.
REQ-011 simm  input  IMM_WIDTH  signed branch offset; dst_in  input  REG_DEPTH  destination index.
REQ-012 out_valid  output  1 / out_ready  input  1  downstream handshake.
REQ-013 ctrl_out  output  5, dst_out  output  REG_DEPTH, val_rm_out  output  WIDTH  registered pass-through.
REQ-014 alu_res, branch_addr  output  WIDTH; sr  output  4 {N,Z,C,V}  status register.

Function
REQ-015 Transfer SHALL occur only when valid and ready are both high on a rising clk edge.
REQ-016 States SHALL be IDLE (output empty), FULL (result held), MUL_BUSY (iterative multiply).
REQ-017 in_ready SHALL be 1 in IDLE, out_ready in FULL, 0 in MUL_BUSY.
REQ-018 Single-cycle ops SHALL present result on out_valid the cycle after acceptance (latency 1).
REQ-019 ex_cmd: 0001 MOV val2; 1001 MVN ~val2; 0010 ADD; 0011 ADC; 0100 SUB; 0101 SBC; 0110 AND; 0111 ORR; 1000 EOR; 1100 MUL; others -> 0, no SR update.
REQ-020 ADC SHALL add sr.C; SBC SHALL compute val_rn - val2 - !sr.C, using sr as registered before acceptance.
REQ-021 C SHALL be carry-out for add, NOT-borrow for subtract; V signed overflow; N = res[WIDTH-1]; Z = res==0; logic ops SHALL update N,Z only.
REQ-022 sr SHALL update on the acceptance edge only when ctrl_in.S=1 and ctrl_in mem_read/mem_write are 0.
REQ-023 mem_read or mem_write set SHALL force ADD regardless of ex_cmd (address generation).
REQ-024 branch_addr SHALL equal pc + sign-extended simm, modulo 2^WIDTH, registered with the result.
REQ-025 FULL with out_ready=1 and in_valid=1 SHALL accept and present the next op in the same edge (no bubble).
REQ-026 flush SHALL drive out_valid=0, abort MUL_BUSY, return to IDLE, and SHALL NOT update sr; flush beats simultaneous acceptance.

Reset
REQ-027 rst low SHALL immediately force IDLE, out_valid=0, sr=0, alu_res=0, branch_addr=0, ctrl_out=0, dst_out=0, val_rm_out=0, multiply counter=0.
REQ-028 rst asserted during MUL_BUSY SHALL discard the partial product.

Configuration
REQ-029 Macro EXE_PIPE_STAGE_MUL_EN SHALL, when defined, implement MUL as shift-add taking WIDTH cycles in MUL_BUSY, low WIDTH bits as result, N,Z updated if S.
REQ-030 Without EXE_PIPE_STAGE_MUL_EN, ex_cmd 1100 SHALL be treated as undefined (result 0, latency 1, no sr update), and MUL_BUSY SHALL not exist.

Structure
REQ-031 A shared package SHALL hold ex_cmd encodings, the ctrl bit positions, and the state enum.
REQ-032 The combinational ALU SHALL be one sub-module, exe_alu, parametrised by WIDTH; the FSM, handshake, sr and multiplier stay in exe_pipe_stage.

Verification
REQ-033 ADD 0x7FFFFFFF + 1, S=1, out_ready=1 -> next cycle alu_res 0x80000000, sr N=1 V=1 C=0 Z=0.
REQ-034 SUB 5 - 5, S=1, then ADC 1 + 1 -> first Z=1 C=1; ADC result 3.
REQ-035 Back-to-back ops with out_ready held 0 for 3 cycles -> in_ready 0, first result stable, second accepted on release edge.
REQ-036 MUL 0x1234 * 0x10 (MUL_EN) -> in_ready low 32 cycles, alu_res 0x12340; flush mid-way -> out_valid 0, sr unchanged.
REQ-037 pc 0x100, simm 0xFFFFFC -> branch_addr 0xFC; rst low mid-MUL -> all outputs 0 asynchronously.
